// File: rtl/car_pass_tx.sv
// car_pass_tx: driver-side keypad/transmitter for the parking entry gate.
// Collects a DIGITS-long 2-bit password from the keypad and plays it out
// digit by digit on pass_out/pass_valid. It then waits for the gate's
// green/red verdict, retries on failure and locks out after MAX_TRIES.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   car_present        entry sensor, car waiting at the gate
//   key_valid/key_code keypad digit strobe and value
//   gate_green/red     gate verdict inputs
//   pass_out/valid     digit presented to the gate (registered)
//   busy               high whenever not idle
//   access_ok          attempt accepted (registered)
//   locked_out         retry limit reached (registered)
// Option: CAR_PASS_TX_LOCK_TIMER_EN makes lockout last LOCK_CYCLES cycles.
// Without it, lockout holds until car_present falls.
module car_pass_tx #(
   parameter int unsigned DIGITS       = 2,
   parameter int unsigned HOLD         = 4,
   parameter int unsigned RESP_TIMEOUT = 16,
   parameter int unsigned MAX_TRIES    = 3,
   parameter int unsigned LOCK_CYCLES  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       car_present,
   input  logic       key_valid,
   input  logic [1:0] key_code,
   input  logic       gate_green,
   input  logic       gate_red,
   output logic [1:0] pass_out,
   output logic       pass_valid,
   output logic       busy,
   output logic       access_ok,
   output logic       locked_out
);

   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam int unsigned TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
   // one extra code so the failing attempt's count never wraps
   localparam int unsigned RW = $clog2(MAX_TRIES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_SEND,
      S_WAIT_RESP,
      S_GRANTED,
      S_LOCKED
   } state_t;

   state_t                 state_q, state_d;
   logic [DIGITS-1:0][1:0] dig_q, dig_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [RW-1:0]          tries_q, tries_d;
   logic [1:0]             pass_out_q, pass_out_d;
   logic                   pass_valid_q, pass_valid_d;
   logic                   access_ok_q, access_ok_d;
   logic                   locked_out_q, locked_out_d;
   logic                   abort, fail, lock_exit;

`ifdef CAR_PASS_TX_LOCK_TIMER_EN
   localparam int unsigned LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   logic [LW-1:0]          lock_q, lock_d;
`endif

   always_comb begin
      state_d      = state_q;
      dig_d        = dig_q;
      idx_d        = idx_q;
      hold_d       = hold_q;
      tmo_d        = tmo_q;
      tries_d      = tries_q;
      pass_out_d   = pass_out_q;
      pass_valid_d = pass_valid_q;
      access_ok_d  = access_ok_q;
      locked_out_d = locked_out_q;
      abort        = 1'b0;
      fail         = 1'b0;
      lock_exit    = 1'b0;
`ifdef CAR_PASS_TX_LOCK_TIMER_EN
      lock_d       = lock_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (car_present) begin
               state_d = S_COLLECT;
               idx_d   = '0;
               dig_d   = '0;
            end
         end
         S_COLLECT: begin
            if (!car_present) begin
               abort = 1'b1;
            end else if (key_valid) begin
               dig_d[idx_q] = key_code;
               if (idx_q == IW'(DIGITS - 1)) begin
                  state_d      = S_SEND;
                  idx_d        = '0;
                  hold_d       = '0;
                  pass_valid_d = 1'b1;
                  // dig_d already holds this key when DIGITS is 1
                  pass_out_d   = dig_d[0];
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_SEND: begin
            if (!car_present) begin
               abort = 1'b1;
            end else if (hold_q == HW'(HOLD - 1)) begin
               hold_d = '0;
               if (idx_q == IW'(DIGITS - 1)) begin
                  state_d      = S_WAIT_RESP;
                  idx_d        = '0;
                  tmo_d        = '0;
                  pass_valid_d = 1'b0;
                  pass_out_d   = 2'd0;
               end else begin
                  idx_d      = idx_q + 1'b1;
                  pass_out_d = dig_q[idx_q + 1'b1];
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_WAIT_RESP: begin
            if (!car_present) begin
               abort = 1'b1;
            end else if (gate_green) begin
               state_d     = S_GRANTED;
               access_ok_d = 1'b1;
            end else if (gate_red || tmo_q == TW'(RESP_TIMEOUT - 1)) begin
               fail = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_GRANTED: begin
            if (!car_present) begin
               state_d     = S_IDLE;
               access_ok_d = 1'b0;
               tries_d     = '0;
            end
         end
         S_LOCKED: begin
`ifdef CAR_PASS_TX_LOCK_TIMER_EN
            if (lock_q == LW'(LOCK_CYCLES - 1)) begin
               lock_exit = 1'b1;
            end else begin
               lock_d = lock_q + 1'b1;
            end
`else
            lock_exit = !car_present;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (fail) begin
         tries_d = tries_q + 1'b1;
         tmo_d   = '0;
         if (tries_d == RW'(MAX_TRIES)) begin
            state_d      = S_LOCKED;
            locked_out_d = 1'b1;
`ifdef CAR_PASS_TX_LOCK_TIMER_EN
            lock_d       = '0;
`endif
         end else begin
            state_d = S_COLLECT;
            idx_d   = '0;
            dig_d   = '0;
         end
      end

      if (lock_exit) begin
         state_d      = S_IDLE;
         locked_out_d = 1'b0;
         tries_d      = '0;
      end

      if (abort) begin
         state_d      = S_IDLE;
         pass_valid_d = 1'b0;
         pass_out_d   = 2'd0;
         idx_d        = '0;
         hold_d       = '0;
         tmo_d        = '0;
         tries_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         dig_q        <= '0;
         idx_q        <= '0;
         hold_q       <= '0;
         tmo_q        <= '0;
         tries_q      <= '0;
         pass_out_q   <= 2'd0;
         pass_valid_q <= 1'b0;
         access_ok_q  <= 1'b0;
         locked_out_q <= 1'b0;
`ifdef CAR_PASS_TX_LOCK_TIMER_EN
         lock_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         dig_q        <= dig_d;
         idx_q        <= idx_d;
         hold_q       <= hold_d;
         tmo_q        <= tmo_d;
         tries_q      <= tries_d;
         pass_out_q   <= pass_out_d;
         pass_valid_q <= pass_valid_d;
         access_ok_q  <= access_ok_d;
         locked_out_q <= locked_out_d;
`ifdef CAR_PASS_TX_LOCK_TIMER_EN
         lock_q       <= lock_d;
`endif
      end
   end

   assign pass_out   = pass_out_q;
   assign pass_valid = pass_valid_q;
   assign access_ok  = access_ok_q;
   assign locked_out = locked_out_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_car_pass_tx.sv
// tb_car_pass_tx: directed bench for car_pass_tx with a phase/age
// reference model compared every cycle plus literal spot checks.
module tb_car_pass_tx;

   localparam int DIGITS       = 2;
   localparam int HOLD         = 4;
   localparam int RESP_TIMEOUT = 16;
   localparam int MAX_TRIES    = 3;
   localparam int LOCK_CYCLES  = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic       car_present;
   logic       key_valid;
   logic [1:0] key_code;
   logic       gate_green;
   logic       gate_red;
   logic [1:0] pass_out;
   logic       pass_valid;
   logic       busy;
   logic       access_ok;
   logic       locked_out;

   car_pass_tx #(
      .DIGITS      (DIGITS),
      .HOLD        (HOLD),
      .RESP_TIMEOUT(RESP_TIMEOUT),
      .MAX_TRIES   (MAX_TRIES),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .car_present(car_present),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .gate_green (gate_green),
      .gate_red   (gate_red),
      .pass_out   (pass_out),
      .pass_valid (pass_valid),
      .busy       (busy),
      .access_ok  (access_ok),
      .locked_out (locked_out)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nbad = 0;

   // Reference model: phase plus cycles spent in it; outputs follow
   // directly from the phase and age.
   typedef enum int {M_IDLE, M_COL, M_SEND, M_WAIT, M_GRANT, M_LOCK} mph_t;
   mph_t ph = M_IDLE;
   mph_t nph;
   int   age = 0;
   int   tries = 0;
   int   keys[$];
   bit   armed = 0;
   bit   leave;

   always @(posedge clk) begin
      nph = ph;
      if (reset) begin
         nph   = M_IDLE;
         tries = 0;
         keys.delete();
         armed = 1;
      end else begin
         case (ph)
            M_IDLE:
               if (car_present) begin
                  nph = M_COL;
                  keys.delete();
               end
            M_COL:
               if (!car_present) begin
                  nph   = M_IDLE;
                  tries = 0;
               end else if (key_valid) begin
                  keys.push_back(int'(key_code));
                  if (keys.size() == DIGITS) nph = M_SEND;
               end
            M_SEND:
               if (!car_present) begin
                  nph   = M_IDLE;
                  tries = 0;
               end else if (age + 1 == DIGITS * HOLD) begin
                  nph = M_WAIT;
               end
            M_WAIT:
               if (!car_present) begin
                  nph   = M_IDLE;
                  tries = 0;
               end else if (gate_green) begin
                  nph = M_GRANT;
               end else if (gate_red || age + 1 == RESP_TIMEOUT) begin
                  tries++;
                  if (tries == MAX_TRIES) begin
                     nph = M_LOCK;
                  end else begin
                     nph = M_COL;
                     keys.delete();
                  end
               end
            M_GRANT:
               if (!car_present) begin
                  nph   = M_IDLE;
                  tries = 0;
               end
            M_LOCK: begin
`ifdef CAR_PASS_TX_LOCK_TIMER_EN
               leave = (age + 1 == LOCK_CYCLES);
`else
               leave = !car_present;
`endif
               if (leave) begin
                  nph   = M_IDLE;
                  tries = 0;
               end
            end
            default: nph = M_IDLE;
         endcase
      end
      age = (nph == ph && !reset) ? age + 1 : 0;
      ph  = nph;
   end

   logic [5:0] exp_v;
   logic [5:0] act_v;
   int         dv;

   always @(negedge clk) begin
      if (armed) begin
         dv = 0;
         if (ph == M_SEND) dv = keys[age / HOLD];
         exp_v = {dv[1:0], ph == M_SEND, ph != M_IDLE,
                  ph == M_GRANT, ph == M_LOCK};
         act_v = {pass_out, pass_valid, busy, access_ok, locked_out};
         nvec++;
         if (act_v !== exp_v) begin
            nbad++;
            $display("FAIL model_cmp t=%0t got=%b want=%b", $time, act_v, exp_v);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic key(input logic [1:0] k);
      key_valid = 1'b1;
      key_code  = k;
      tick(1);
      key_valid = 1'b0;
      key_code  = 2'd0;
   endtask

   // enter both digits, then wait out the whole send; ends on WAIT entry
   task automatic send2(input logic [1:0] a, input logic [1:0] b);
      key(a);
      key(b);
      tick(DIGITS * HOLD);
   endtask

   task automatic red();
      gate_red = 1'b1;
      tick(1);
      gate_red = 1'b0;
   endtask

   task automatic clear_lock();
`ifdef CAR_PASS_TX_LOCK_TIMER_EN
      tick(LOCK_CYCLES);
`endif
      car_present = 1'b0;
      tick(1);
      chk("lock_clear", {31'd0, locked_out}, 32'd0);
      chk("lock_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      car_present = 1'b0;
      key_valid   = 1'b0;
      key_code    = 2'd0;
      gate_green  = 1'b0;
      gate_red    = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("rst_outs", {26'd0, pass_out, pass_valid, busy, access_ok,
                       locked_out}, 32'd0);

      // accepted attempt, keys 2 then 1
      car_present = 1'b1;
      tick(1);
      key(2'd2);
      key(2'd1);
      chk("send_d0", {30'd0, pass_out}, 32'd2);
      chk("send_v0", {31'd0, pass_valid}, 32'd1);
      tick(HOLD);
      chk("send_d1", {30'd0, pass_out}, 32'd1);
      tick(HOLD);
      chk("send_end", {31'd0, pass_valid}, 32'd0);
      tick(2);
      gate_green = 1'b1;
      tick(1);
      gate_green = 1'b0;
      chk("grant", {31'd0, access_ok}, 32'd1);
      car_present = 1'b0;
      tick(1);
      chk("grant_clr", {31'd0, access_ok}, 32'd0);
      chk("grant_idle", {31'd0, busy}, 32'd0);

      // three rejected attempts
      car_present = 1'b1;
      tick(1);
      send2(2'd0, 2'd3);
      red();
      chk("red1_nolock", {31'd0, locked_out}, 32'd0);
      chk("red1_busy", {31'd0, busy}, 32'd1);
      send2(2'd1, 2'd1);
      red();
      chk("red2_nolock", {31'd0, locked_out}, 32'd0);
      send2(2'd2, 2'd2);
      red();
      chk("red3_lock", {31'd0, locked_out}, 32'd1);
      chk("red3_pv", {31'd0, pass_valid}, 32'd0);
`ifdef CAR_PASS_TX_LOCK_TIMER_EN
      tick(LOCK_CYCLES - 1);
      chk("lock_hold", {31'd0, locked_out}, 32'd1);
      tick(1);
      chk("lock_expire", {31'd0, locked_out}, 32'd0);
      chk("lock_exp_idle", {31'd0, busy}, 32'd0);
      tick(1);
      chk("lock_recollect", {31'd0, busy}, 32'd1);
      car_present = 1'b0;
      tick(1);
`else
      tick(5);
      chk("lock_hold", {31'd0, locked_out}, 32'd1);
      car_present = 1'b0;
      tick(1);
      chk("lock_clear", {31'd0, locked_out}, 32'd0);
      chk("lock_idle", {31'd0, busy}, 32'd0);
`endif

      // response timeouts; stray key and early verdict are ignored
      car_present = 1'b1;
      tick(1);
      send2(2'd1, 2'd2);
      key(2'd3);
      tick(RESP_TIMEOUT - 1);
      gate_green = 1'b1;
      tick(1);
      gate_green = 1'b0;
      chk("green_in_col", {31'd0, access_ok}, 32'd0);
      send2(2'd3, 2'd3);
      tick(RESP_TIMEOUT);
      send2(2'd2, 2'd0);
      tick(RESP_TIMEOUT - 1);
      chk("tmo_edge", {31'd0, locked_out}, 32'd0);
      tick(1);
      chk("tmo_lock", {31'd0, locked_out}, 32'd1);
      clear_lock();

      // simultaneous green and red: green wins
      car_present = 1'b1;
      tick(1);
      send2(2'd3, 2'd0);
      gate_green = 1'b1;
      gate_red   = 1'b1;
      tick(1);
      gate_green = 1'b0;
      gate_red   = 1'b0;
      chk("both_grant", {31'd0, access_ok}, 32'd1);
      chk("both_nolock", {31'd0, locked_out}, 32'd0);
      car_present = 1'b0;
      tick(1);

      // abort mid-send clears the try count
      car_present = 1'b1;
      tick(1);
      send2(2'd2, 2'd3);
      red();
      key(2'd1);
      key(2'd3);
      tick(HOLD);
      chk("abort_d1", {30'd0, pass_out}, 32'd3);
      car_present = 1'b0;
      tick(1);
      chk("abort_pv", {31'd0, pass_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      car_present = 1'b1;
      tick(1);
      send2(2'd0, 2'd1);
      red();
      send2(2'd1, 2'd0);
      red();
      chk("tries_cleared", {31'd0, locked_out}, 32'd0);
      send2(2'd0, 2'd0);
      red();
      chk("tries_lock", {31'd0, locked_out}, 32'd1);
      clear_lock();

      // reset mid-collect restarts from digit 0
      car_present = 1'b1;
      tick(1);
      key(2'd2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      tick(1);
      key(2'd1);
      key(2'd2);
      chk("midrst_d0", {30'd0, pass_out}, 32'd1);
      car_present = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/car_pass_tx.md
Name: car_pass_tx

Overview:
Driver-side keypad/transmitter for the car-parking entry gate. It collects a DIGITS-long password from a keypad and sends it digit by digit to the gate's 2-bit password input. It then waits for the gate's GREEN/RED verdict and retries on failure. After MAX_TRIES failed attempts it locks out. It sits between the keypad and the entry-gate controller, sharing the entry sensor.

Parameters:
DIGITS, 2, number of 2-bit password digits per attempt (1..8)
HOLD, 4, cycles each digit is held on pass_out with pass_valid high (>=1)
RESP_TIMEOUT, 16, cycles to wait for gate verdict before counting a failure (>=1)
MAX_TRIES, 3, failed attempts before lockout (>=1)
LOCK_CYCLES, 64, lockout duration when CAR_PASS_TX_LOCK_TIMER_EN is defined

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
car_present  input  1  entry sensor; car waiting at gate
key_valid  input  1  one-cycle strobe, keypad digit available
key_code  input  2  keypad digit value
gate_green  input  1  gate verdict: password accepted
gate_red  input  1  gate verdict: password rejected
pass_out  output  2  digit currently presented to gate
pass_valid  output  1  pass_out holds a valid digit
busy  output  1  high in any state except IDLE
access_ok  output  1  attempt accepted, car may enter
locked_out  output  1  retry limit reached

Behaviour:
- Reset: state IDLE; all outputs 0; digit buffer, digit index, hold/timeout counters and try counter all 0.
- States: IDLE, COLLECT, SEND, WAIT_RESP, GRANTED, LOCKED.
- IDLE: car_present=1 -> COLLECT on the next edge.
- COLLECT: each key_valid stores key_code at buffer[idx], idx starting at 0. The key accepted at idx=DIGITS-1 -> SEND on the next edge. key_valid is ignored in every other state.
- SEND: pass_valid=1 in the first SEND cycle, i.e. 1 cycle after the last key. Digit 0 first. Each digit is held exactly HOLD cycles and digits are back to back, so pass_valid is high for DIGITS*HOLD cycles.
- Leaving SEND -> WAIT_RESP: pass_valid=0 and pass_out=0.
- WAIT_RESP: the timeout counter starts at 0.
  - gate_green=1 -> GRANTED. This takes priority if gate_green and gate_red are high together.
  - gate_red=1 -> failure.
  - Counter reaches RESP_TIMEOUT-1 with no verdict -> failure.
  - Verdicts outside WAIT_RESP are ignored.
- Failure: tries increments. If the new value equals MAX_TRIES -> LOCKED; otherwise -> COLLECT with idx and buffer cleared.
- GRANTED: access_ok=1. It holds until car_present=0, then -> IDLE with tries cleared.
- Abort: car_present=0 in COLLECT/SEND/WAIT_RESP -> IDLE on the next edge. Outputs drop to 0 and tries is cleared.
- LOCKED: locked_out=1 and pass_valid=0. Exit rule is set by the optional feature. On exit, tries is cleared.
- Registered outputs: pass_out, pass_valid, access_ok and locked_out are registered and change only on clock edges.
- Reset mid-operation: returns to the reset state on the next edge regardless of current state.
- Counter widths: $clog2 of their limit (minimum 1 bit); no wrap is reachable.

Optional Feature:
CAR_PASS_TX_LOCK_TIMER_EN
- Defined: LOCKED lasts exactly LOCK_CYCLES cycles, then -> IDLE. car_present falling does not shorten it. If car_present is still 1 on IDLE entry, COLLECT follows next edge.
- Undefined: LOCKED persists until car_present=0, then -> IDLE. No lock timer hardware is built.

Test Plan:
- Reset held 3 cycles, then released with car_present=0 -> all outputs 0, busy=0.
- car_present=1, keys 2 then 1, gate_green pulsed 2 cycles after pass_valid falls -> pass_out=2 for 4 cycles, then 1 for 4 cycles; access_ok=1; car_present=0 -> IDLE, access_ok=0 next cycle.
- Three attempts answered with gate_red -> re-enters COLLECT after attempts 1 and 2; locked_out=1 after attempt 3. Without macro it clears on car_present=0; with macro it clears after 64 cycles.
- No verdict after send -> failure counted 16 cycles after WAIT_RESP entry, back to COLLECT; tries=1 visible via lockout after 2 more timeouts.
- gate_green and gate_red asserted the same cycle in WAIT_RESP -> access_ok=1, no failure counted.
- car_present dropped mid-SEND after first digit -> pass_valid=0 and busy=0 next cycle. A new attempt starts with tries=0.
